// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int W_OUT_DEF = 16;
    // One extra iteration so the bit just above the result lands in acc[W_OUT].
    localparam int ITERS     = W_OUT_DEF + 1;
    localparam int CNT_W     = $clog2(ITERS + 1);

    localparam logic [3:0] DIGIT_ADJ = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double-dabble: digits >= 8 after a right shift lose 3.
module bcd_digit_adjust
    import bcd_conv_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? (digit_i - DIGIT_ADJ) : digit_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble shift per clock.
// Optional build macro BCD_SAT_EN saturates bin_out to all ones on overflow.
module bcd_to_bin_seq
    import bcd_conv_pkg::*;
#(
    parameter int N_DIGITS = 5,
    parameter int W_OUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [W_OUT-1:0]      bin_out,
    output logic                  overflow,
    output logic                  invalid
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int SR_W  = BCD_W + ITERS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_q, sr_d, sr_shift;
    logic [BCD_W-1:0]   bcd_adj;
    logic               inv_pend_q, inv_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W_OUT-1:0]   bin_q, bin_d;
    logic               ovf_q, ovf_d;
    logic               invl_q, invl_d;

    function automatic logic digit_invalid(input logic [BCD_W-1:0] b);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [W_OUT-1:0] sat_result(input logic [ITERS-1:0] acc);
`ifdef BCD_SAT_EN
        return acc[W_OUT] ? {W_OUT{1'b1}} : acc[W_OUT-1:0];
`else
        return acc[W_OUT-1:0];
`endif
    endfunction

    assign sr_shift = sr_q >> 1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i(sr_shift[ITERS + 4*g +: 4]),
            .digit_o(bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        inv_pend_d = inv_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bin_d      = bin_q;
        ovf_d      = ovf_q;
        invl_d     = invl_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d  = 1'b0;
                    invl_d = 1'b0;
                    if (digit_invalid(bcd_in)) begin
                        inv_pend_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        inv_pend_d = 1'b0;
                        sr_d       = {bcd_in, {ITERS{1'b0}}};
                        cnt_d      = '0;
                        busy_d     = 1'b1;
                        state_d    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_d  = {bcd_adj, sr_shift[ITERS-1:0]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (inv_pend_q) begin
                    bin_d  = '0;
                    ovf_d  = 1'b0;
                    invl_d = 1'b1;
                end else begin
                    bin_d  = sat_result(sr_q[ITERS-1:0]);
                    ovf_d  = sr_q[W_OUT];
                    invl_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The shift register carries data only; everything observable is reset.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            inv_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bin_q      <= '0;
            ovf_q      <= 1'b0;
            invl_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inv_pend_q <= inv_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bin_q      <= bin_d;
            ovf_q      <= ovf_d;
            invl_q     <= invl_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bin_out  = bin_q;
    assign overflow = ovf_q;
    assign invalid  = invl_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus pushes expected results, a monitor checks each done.
module tb_bcd_to_bin_seq;

    typedef struct {
        logic [15:0] bin;
        logic        ovf;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] bin_out;
    logic        overflow;
    logic        invalid;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef BCD_SAT_EN
    localparam logic [15:0] EXP_65536 = 16'hFFFF;
    localparam logic [15:0] EXP_99999 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_65536 = 16'h0000;
    localparam logic [15:0] EXP_99999 = 16'h869F;
`endif

    bcd_to_bin_seq dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bcd_in(bcd_in),
        .busy(busy),
        .done(done),
        .bin_out(bin_out),
        .overflow(overflow),
        .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bin_out", {16'd0, bin_out}, {16'd0, e.bin});
                    check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    check("invalid", {31'd0, invalid}, {31'd0, e.inv});
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] b, input logic o, input logic i);
        exp_t e;
        e.bin = b;
        e.ovf = o;
        e.inv = i;
        exp_q.push_back(e);
    endtask

    task automatic run_conv(input string name, input logic [19:0] bcd, input logic [15:0] eb,
                            input logic eo, input logic ei, input int exp_lat, input int exp_busy);
        int k;
        int nb;
        bit seen;
        @(negedge clk);
        bcd_in = bcd;
        start  = 1'b1;
        push_exp(eb, eo, ei);
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 20'h77777;
        k = 0;
        nb = 0;
        seen = 0;
        while (!seen && k < 40) begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            k++;
            if (done) seen = 1;
        end
        check({name, "_latency"}, seen ? k : -1, exp_lat);
        check({name, "_busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        int k;
        int d1;
        int d2;
        int nd;
        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 20'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bin", {16'd0, bin_out}, 32'd0);
        check("rst_flags", {30'd0, overflow, invalid}, 32'd0);
        reset = 1'b0;

        run_conv("max16", 20'h65535, 16'hFFFF, 1'b0, 1'b0, 18, 17);
        run_conv("ovf_65536", 20'h65536, EXP_65536, 1'b1, 1'b0, 18, 17);
        run_conv("ovf_99999", 20'h99999, EXP_99999, 1'b1, 1'b0, 18, 17);
        run_conv("bad_digit", 20'h0A00F, 16'h0000, 1'b0, 1'b1, 1, 0);

        // Back-to-back with start held high through the first done.
        @(negedge clk);
        bcd_in = 20'h00090;
        start  = 1'b1;
        push_exp(16'h005A, 1'b0, 1'b0);
        push_exp(16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bcd_in = 20'h00000;
        k = 0;
        d1 = -1;
        d2 = -1;
        while (d2 < 0 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                if (d1 < 0) d1 = k;
                else begin
                    d2 = k;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_latency", d1, 18);
        check("b2b_second_gap", (d2 < 0) ? -1 : d2 - d1, 19);

        // Reset in the middle of a conversion aborts it silently.
        @(negedge clk);
        bcd_in = 20'h65535;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bin", {16'd0, bin_out}, 32'd0);
        check("abort_flags", {30'd0, overflow, invalid}, 32'd0);
        nd = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        run_conv("after_abort", 20'h00001, 16'h0001, 1'b0, 1'b0, 18, 17);

        // A start pulse during SHIFT must be dropped.
        @(negedge clk);
        bcd_in = 20'h00255;
        start  = 1'b1;
        push_exp(16'h00FF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        bcd_in = 20'h12345;
        start  = 1'b1;
        @(posedge clk);
        #1;
        k++;
        start = 1'b0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("ignored_start_latency", done ? k : -1, 18);
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("ignored_start_single_done", nd, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
